if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS32 pipeline. It sits directly upstream of ID and feeds `control_main` and the stall-detection unit through the IF/ID pipeline register. The block owns:
- the PC and next-PC selection;
- a valid/ack handshake with instruction memory, tolerating wait states;
- a one-entry hold buffer for instructions returned while ID is stalled;
- IF/ID flush on taken branches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clock`  in  1  pipeline clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_write`  in  1  PC write enable from the stall-detection unit.
- `if_id_write`  in  1  IF/ID write enable from the stall-detection unit.
- `branch_taken`  in  1  one-cycle redirect pulse from branch resolution.
- `branch_target`  in  32  redirect address, valid while `branch_taken`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and no ack has been seen.
- `imem_ack`  in  1  request accepted and data valid this cycle; ack in the same cycle as req is allowed.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `pc`  out  32  current PC, the next instruction to be fetched.
- `if_id_instr`  out  32  IF/ID instruction.
- `if_id_pc4`  out  32  IF/ID PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- Signal definitions:
  - `adv` = `pc_write` & `if_id_write`; any 0 is treated as a stall.
  - `accept` = `imem_ack` in FETCH or DRAIN.
- Registers: `pc`, `fetch_addr` (drives `imem_addr`), `hold_instr`, `state`, and the IF/ID fields.
- States: IDLE, FETCH, HOLD, DRAIN. `imem_req`=1 only in FETCH and DRAIN.
- IDLE: entered on reset; goes to FETCH on the first edge after reset release.
- FETCH, `adv`=1, ack=1:
  - IF/ID <= {`imem_rdata`, `fetch_addr`+4, valid=1}.
  - `pc` and `fetch_addr` <= `pc`+4.
  - Stay in FETCH.
- FETCH, `adv`=1, ack=0: IF/ID <= bubble (instr=32'h0 NOP, pc4=0, valid=0). PC holds.
- FETCH, `adv`=0, ack=1: `hold_instr` <= `imem_rdata`; go to HOLD. IF/ID and PC hold.
- FETCH, `adv`=0, ack=0: everything holds and the request stays asserted.
- HOLD, `adv`=1:
  - IF/ID <= {`hold_instr`, `pc`+4, 1}.
  - `pc` and `fetch_addr` <= `pc`+4.
  - Go to FETCH.
- HOLD, `adv`=0: hold.
- `branch_taken`=1 has priority over all of the above, including a stall:
  - IF/ID <= bubble and `pc` <= `branch_target`.
  - Any held or arriving instruction is discarded.
  - From FETCH with ack=0: go to DRAIN. `fetch_addr` keeps the old address so the outstanding request stays legal.
  - Otherwise: `fetch_addr` <= `branch_target`; go to FETCH.
- DRAIN:
  - On ack: data is discarded, `fetch_addr` <= `pc`, go to FETCH.
  - A further `branch_taken` in DRAIN overwrites `pc`; the latest target wins.
  - While in DRAIN, if `if_id_write`=1, IF/ID <= bubble.
- Arithmetic: PC+4 is a 32-bit add, wrapping at 32'hFFFF_FFFC to 0. No alignment check.

## Timing
- Reset values, applied asynchronously: `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `imem_req`=0, `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0, state=IDLE, `hold_instr`=0.
- Reset mid-transaction: the outstanding request is abandoned. Instruction memory shares `reset` and must drop it.
- Latency with a zero-wait-state memory: the word for address A appears in IF/ID one edge after the first cycle `imem_req`=1 with `imem_addr`=A. Throughput is one instruction per cycle.
- Branch penalty: the IF/ID bubble appears on the edge after `branch_taken`. The first fetch at the target is requested in the following cycle, or after the drain ack.
- `imem_addr` never changes while `imem_req`=1 before ack.

## Structure
- Shared `constants.h`:
  - `` `NOP `` (32'h0);
  - `` `IF_IDLE ``, `` `IF_FETCH ``, `` `IF_HOLD ``, `` `IF_DRAIN `` (2-bit encodings);
  - `` `RESET_PC_DEFAULT ``.
- One natural sub-module: `if_id_pipe_reg`. It holds instr/pc4/valid, with write enable and synchronous flush-to-bubble, and is instantiated once.

## Test plan
- Reset release with `imem_ack` tied 1, no stalls: `imem_addr` = 0, 4, 8 on consecutive cycles. IF/ID shows {mem[0], pc4=4, valid=1} two edges after release.
- Ack delayed 2 cycles: `imem_addr`=0 held for 3 cycles. `if_id_valid`=0 on the two wait edges, then mem[0] is loaded.
- `pc_write`=`if_id_write`=0 for 3 cycles with ack on the first: state goes to HOLD, `imem_req`=0, IF/ID unchanged. After release, IF/ID = held word and the next request is at `pc`+4.
- `branch_taken`, target 0x100, while the request at 0x8 is un-acked: DRAIN holds `imem_addr`=0x8 until ack. That data is dropped, the next request is 0x100, and IF/ID valid=0.
- `branch_taken` during a stall (`if_id_write`=0): IF/ID becomes {0, 0, 0} anyway and `pc`=target.
- `reset` asserted asynchronously in DRAIN: all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the MIPS32 instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with load enable and
// synchronous flush-to-bubble (flush wins over load).
module if_id_pipe_reg
  import if_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr <= NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC/next-PC selection, imem valid/ack handshake,
// one-entry hold buffer for stalls, and IF/ID flush on taken branches.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  if_state_t   state, state_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic        adv;
  logic        pipe_load, pipe_flush;
  logic [31:0] pipe_instr, pipe_pc4;

  assign adv       = pc_write & if_id_write;
  assign imem_addr = fetch_addr;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_addr_nxt = fetch_addr;
    hold_instr_nxt = hold_instr;
    pipe_load      = 1'b0;
    pipe_flush     = 1'b0;
    imem_req       = (state == IF_FETCH) || (state == IF_DRAIN);

    if (branch_taken) begin
      pipe_flush = 1'b1;
      pc_nxt     = branch_target;
      // An un-acked request must keep its address, so drain it first.
      if (imem_req && !imem_ack) begin
        state_nxt = IF_DRAIN;
      end else begin
        fetch_addr_nxt = branch_target;
        state_nxt      = IF_FETCH;
      end
    end else begin
      unique case (state)
        IF_IDLE: state_nxt = IF_FETCH;
        IF_FETCH: begin
          if (adv) begin
            if (imem_ack) begin
              pipe_load      = 1'b1;
              pc_nxt         = pc_plus4(pc);
              fetch_addr_nxt = pc_plus4(pc);
            end else begin
              pipe_flush = 1'b1;
            end
          end else if (imem_ack) begin
            hold_instr_nxt = imem_rdata;
            state_nxt      = IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (adv) begin
            pipe_load      = 1'b1;
            pc_nxt         = pc_plus4(pc);
            fetch_addr_nxt = pc_plus4(pc);
            state_nxt      = IF_FETCH;
          end
        end
        IF_DRAIN: begin
          pipe_flush = if_id_write;
          if (imem_ack) begin
            fetch_addr_nxt = pc;
            state_nxt      = IF_FETCH;
          end
        end
        default: state_nxt = IF_IDLE;
      endcase
    end
  end

  assign pipe_instr = (state == IF_HOLD) ? hold_instr : imem_rdata;
  assign pipe_pc4   = (state == IF_HOLD) ? pc_plus4(pc) : pc_plus4(fetch_addr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IF_IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      hold_instr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetch_addr <= fetch_addr_nxt;
      hold_instr <= hold_instr_nxt;
    end
  end

  if_id_pipe_reg u_if_id (
    .clock      (clock),
    .reset      (reset),
    .load       (pipe_load),
    .flush      (pipe_flush),
    .next_instr (pipe_instr),
    .next_pc4   (pipe_pc4),
    .instr      (if_id_instr),
    .pc4        (if_id_pc4),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pc_write = 1'b0, if_id_write = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        if_id_valid;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Model: started = first edge after reset seen; held = words fetched during
  // a stall; draining = a request is outstanding whose data must be dropped.
  bit          started, draining;
  logic [31:0] m_pc, m_addr;
  logic [31:0] held[$];
  logic [31:0] e_instr, e_pc4;
  logic        e_valid;

  function automatic bit m_req();
    return started && (held.size() == 0);
  endfunction

  task automatic model_reset();
    started  = 0;
    draining = 0;
    m_pc     = RST_PC;
    m_addr   = RST_PC;
    held.delete();
    e_instr  = '0;
    e_pc4    = '0;
    e_valid  = 1'b0;
  endtask

  task automatic bubble();
    e_instr = '0;
    e_pc4   = '0;
    e_valid = 1'b0;
  endtask

  task automatic model_step();
    bit req_m, got, adv;
    req_m = m_req();
    got   = req_m && imem_ack;
    adv   = pc_write && if_id_write;
    if (branch_taken) begin
      bubble();
      m_pc = branch_target;
      held.delete();
      if (req_m && !got) draining = 1;
      else begin
        draining = 0;
        m_addr   = branch_target;
      end
      started = 1;
    end else if (!started) begin
      started = 1;
    end else if (draining) begin
      if (if_id_write) bubble();
      if (got) begin
        draining = 0;
        m_addr   = m_pc;
      end
    end else if (held.size() != 0) begin
      if (adv) begin
        e_instr = held[0];
        e_pc4   = m_pc + 32'd4;
        e_valid = 1'b1;
        held.delete();
        m_pc    = m_pc + 32'd4;
        m_addr  = m_pc;
      end
    end else if (got) begin
      if (adv) begin
        e_instr = mem_word(m_addr);
        e_pc4   = m_addr + 32'd4;
        e_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_addr  = m_pc;
      end else begin
        held.push_back(mem_word(m_addr));
      end
    end else if (adv) begin
      bubble();
    end
  endtask

  task automatic check_outputs();
    check("imem_req",    {31'b0, imem_req},    {31'b0, m_req()});
    check("imem_addr",   imem_addr,            m_addr);
    check("pc",          pc,                   m_pc);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e_valid});
    check("if_id_instr", if_id_instr,          e_instr);
    check("if_id_pc4",   if_id_pc4,            e_pc4);
  endtask

  // mode 0: ideal memory, no stalls/branches; mode 1: fully random.
  task automatic drive_random(input int mode);
    if (mode == 0) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      branch_taken = 1'b0;
      imem_ack     = imem_req;
    end else begin
      pc_write     = ($urandom % 6) != 0;
      if_id_write  = ($urandom % 6) != 0;
      branch_taken = started && (($urandom % 8) == 0);
      imem_ack     = imem_req && (($urandom % 3) != 0);
    end
    branch_target = (($urandom % 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    imem_rdata    = imem_ack ? mem_word(imem_addr) : $urandom;
  endtask

  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      drive_random(mode);
      model_step();
      @(negedge clock);
      check_outputs();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b1;

    run_cycles(20, 0);
    run_cycles(1500, 1);
    apply_reset();
    run_cycles(1500, 1);

    // Directed: async reset while draining a branch-abandoned request.
    apply_reset();
    pc_write = 1'b1; if_id_write = 1'b1; branch_taken = 1'b0; imem_ack = 1'b0;
    model_step();
    @(negedge clock);
    check_outputs();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    imem_ack      = 1'b0;
    model_step();
    @(negedge clock);
    check_outputs();
    check("drain_addr", imem_addr, RST_PC);
    check("drain_pc",   pc,        32'h0000_0100);
    branch_taken = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clock);
    reset = 1'b1;
    run_cycles(200, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
